// File: rtl/dip_debouncer.sv
// -----------------------------------------------------------------------------
// dip_debouncer
//
// Purpose:
//   Conditions the raw GPIO_DIP1 switch level before it reaches the
//   LED-driving top-level logic. The asynchronous input is brought into the
//   clk domain through a short synchroniser chain. Contact bounce is then
//   filtered by a four-state FSM that works with a stability counter: a new
//   level is accepted only after the synchronised signal has held it for
//   DEBOUNCE_CYCLES consecutive clock edges.
//
// Parameters:
//   SYNC_STAGES      synchroniser depth, 2..4
//   DEBOUNCE_CYCLES  consecutive samples a new level must hold, >= 2
//   CNT_W            stability counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   TGL_W            accepted-transition counter width
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   dip_in        in   raw switch level (asynchronous, may bounce)
//   dip_clean     out  debounced level, registered
//   rise_pulse    out  one-cycle pulse when dip_clean goes 0 -> 1
//   fall_pulse    out  one-cycle pulse when dip_clean goes 1 -> 0
//   toggle_count  out  accepted transitions, wraps modulo 2**TGL_W
//   busy          out  high while a candidate level is being qualified
// -----------------------------------------------------------------------------
module dip_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int TGL_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dip_in,
    output logic             dip_clean,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [TGL_W-1:0] toggle_count,
    output logic             busy
);

    // Parameter sanity checks. These run at elaboration and produce no logic.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("dip_debouncer: SYNC_STAGES must be in the range 2..4");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
            $error("dip_debouncer: DEBOUNCE_CYCLES must be at least 2");
        end
        if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
            $error("dip_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_WAIT_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_WAIT_LO   = 2'd3
    } state_t;

    // The counter counts edges on which s has shown the candidate level. The
    // first such edge loads 1, so the level is accepted on the edge where the
    // counter already holds DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TGL_W-1:0] TGL_ONE  = TGL_W'(1);

    // -------------------------------------------------------------------------
    // Synchroniser
    // dip_in enters at bit 0 and only the last stage is used downstream.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    // NOTE: the synchroniser flops are reset along with all other state. A
    // clean 0 after reset lets the FSM start in STABLE_LO without seeing X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment is required here. Each stage must
            // take the old value of the stage before it, so that the chain
            // shifts by one stage per clock.
            sync_q <= {sync_q[SYNC_STAGES-2:0], dip_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debounce FSM
    // All outputs are registered in the same block as the state, so busy always
    // matches the WAIT states. The pulses stay high for one cycle only because
    // they are cleared on every edge unless an acceptance sets them again.
    // -------------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_STABLE_LO;
            cnt          <= '0;
            dip_clean    <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            toggle_count <= '0;
            busy         <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;

            case (state)
                ST_STABLE_LO: begin
                    if (s) begin
                        state <= ST_WAIT_HI;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end

                ST_WAIT_HI: begin
                    if (!s) begin
                        // The high level did not last long enough: treat it
                        // as bounce and drop it.
                        state <= ST_STABLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= ST_STABLE_HI;
                        cnt          <= '0;
                        busy         <= 1'b0;
                        dip_clean    <= 1'b1;
                        rise_pulse   <= 1'b1;
                        toggle_count <= toggle_count + TGL_ONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_STABLE_HI: begin
                    if (!s) begin
                        state <= ST_WAIT_LO;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end

                ST_WAIT_LO: begin
                    if (s) begin
                        state <= ST_STABLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= ST_STABLE_LO;
                        cnt          <= '0;
                        busy         <= 1'b0;
                        dip_clean    <= 1'b0;
                        fall_pulse   <= 1'b1;
                        toggle_count <= toggle_count + TGL_ONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    // The encoding covers all four codes, so this branch is
                    // unreachable. It still returns the FSM to a known
                    // low state.
                    state     <= ST_STABLE_LO;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    dip_clean <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dip_debouncer.sv
// -----------------------------------------------------------------------------
// tb_dip_debouncer
//
// Self-checking bench for dip_debouncer, configured with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, CNT_W=3, TGL_W=3 and a 10 ns clock.
//
// The reference model does not track FSM states. It keeps the raw samples in
// a delay line and a run length of consecutive edges on which the delayed
// sample differs from the clean level. When that run reaches DEBOUNCE_CYCLES,
// the level is accepted.
//
// Inputs change on the falling edge. Outputs are sampled on the falling edge
// as well.
// -----------------------------------------------------------------------------
module tb_dip_debouncer;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int CNT_W = 3;
    localparam int TGL_W = 3;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             dip_in = 1'b0;
    logic             dip_clean;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [TGL_W-1:0] toggle_count;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dip_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CNT_W),
        .TGL_W          (TGL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dip_in      (dip_in),
        .dip_clean   (dip_clean),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .toggle_count(toggle_count),
        .busy        (busy)
    );

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [SYNC-1:0]  raw;    // raw samples, oldest sample in the MSB
        logic             clean;
        logic             rise;
        logic             fall;
        logic             busy;
        logic [TGL_W-1:0] tgl;
        logic [7:0]       run;    // consecutive edges seen at the other level
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, logic din);
        model_t nxt = cur;
        logic   seen = cur.raw[SYNC-1];   // the level the filter sees now
        nxt.raw  = {cur.raw[SYNC-2:0], din};
        nxt.rise = 1'b0;
        nxt.fall = 1'b0;
        if (seen != cur.clean) begin
            nxt.run = cur.run + 8'd1;
            if (nxt.run == 8'(DEB)) begin
                nxt.clean = seen;
                nxt.rise  = seen;
                nxt.fall  = ~seen;
                nxt.tgl   = cur.tgl + TGL_W'(1);
                nxt.run   = 8'd0;
            end
        end else begin
            nxt.run = 8'd0;
        end
        nxt.busy = (nxt.run != 8'd0);
        return nxt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, dip_in);
    end

    logic [6:0] obs;
    assign obs = {dip_clean, rise_pulse, fall_pulse, busy, toggle_count};

    function automatic logic [6:0] exp_vec();
        return {m.clean, m.rise, m.fall, m.busy, m.tgl};
    endfunction

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n  = 1'b0;
        dip_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (obs !== 7'd0) begin
                n_err++;
                $display("FAIL reset_state: got %b want 0000000", obs);
            end
        end
        #2 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_idle: got %b want %b", obs, exp_vec());
            end
        end
    endtask

    // The first sampling edge of the step is j=0.
    task automatic test_clean_step();
        logic [6:0] want;
        dip_in = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            want = {(j >= 5), (j == 5), 1'b0, (j >= 2 && j <= 4),
                    (j >= 5) ? 3'd1 : 3'd0};
            n_vec++;
            if (obs !== want) begin
                n_err++;
                $display("FAIL clean_step j=%0d: got %b want %b", j, obs, want);
            end
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL clean_step_model j=%0d: got %b want %b", j, obs, exp_vec());
            end
        end
        dip_in = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL clean_step_release: got %b want %b", obs, exp_vec());
            end
        end
    endtask

    task automatic test_bounce_reject();
        logic lvl [12] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        for (int j = 0; j < 12; j++) begin
            dip_in = lvl[j];
            @(negedge clk);
            n_vec++;
            if (dip_clean !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0
                || toggle_count !== 3'd2 || obs !== exp_vec()) begin
                n_err++;
                $display("FAIL bounce_reject j=%0d: got %b want %b", j, obs, exp_vec());
            end
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_reject_busy: got %b want 0", busy);
        end
    endtask

    // Raw input: 3 high, 1 low, then 10 high. The filter sees it two edges
    // later, so the 4th consecutive high sample arrives on edge 9.
    task automatic test_bounce_settle();
        int rises   = 0;
        int rise_at = -1;
        for (int j = 0; j < 14; j++) begin
            dip_in = (j == 3) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rise_pulse === 1'b1) begin
                rises++;
                rise_at = j;
            end
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL bounce_settle_model j=%0d: got %b want %b", j, obs, exp_vec());
            end
        end
        n_vec++;
        if (rises != 1 || rise_at != 9) begin
            n_err++;
            $display("FAIL bounce_settle_pulse: got %0d pulses at %0d want 1 at 9", rises, rise_at);
        end
        n_vec++;
        if (toggle_count !== 3'd3) begin
            n_err++;
            $display("FAIL bounce_settle_count: got %0d want 3", toggle_count);
        end
        dip_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_square_wave();
        logic applied [100];
        logic want_clean;
        int   accepted = 0;
        rst_n  = 1'b0;
        dip_in = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 100; n++) begin
            if (n % 10 == 0) dip_in = ((n / 10) % 2 == 0);
            @(negedge clk);
            applied[n] = dip_in;
            want_clean = (n >= 5) ? applied[n-5] : 1'b0;
            n_vec++;
            if (dip_clean !== want_clean || obs !== exp_vec()) begin
                n_err++;
                $display("FAIL square_wave n=%0d: got %b want %b clean %b", n, obs, exp_vec(), want_clean);
            end
            if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
                accepted++;
                n_vec++;
                if (rise_pulse !== accepted[0] || fall_pulse !== ~accepted[0]
                    || toggle_count !== 3'(accepted)) begin
                    n_err++;
                    $display("FAIL square_wave_pulse k=%0d: got r%b f%b cnt %0d want cnt %0d",
                             accepted, rise_pulse, fall_pulse, toggle_count, accepted % 8);
                end
            end
        end
        n_vec++;
        if (accepted != 10 || toggle_count !== 3'd2) begin
            n_err++;
            $display("FAIL square_wave_wrap: got %0d transitions cnt %0d want 10 cnt 2", accepted, toggle_count);
        end
    endtask

    task automatic test_reset_mid_qual();
        bit found = 0;
        dip_in = 1'b1;
        for (int j = 0; j < 10 && !found; j++) begin
            @(negedge clk);
            if (m.run == 8'd2) found = 1;
        end
        n_vec++;
        if (!found || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_qual_setup: got busy %b found %0d want busy 1 found 1", busy, found);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 7'd0) begin
            n_err++;
            $display("FAIL mid_qual_reset: got %b want 0000000", obs);
        end
        repeat (2) @(negedge clk);
    endtask

    // dip_in is still high from the previous scenario while reset is asserted.
    task automatic test_reset_release_high();
        logic [6:0] want;
        #2 rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            want = {(j >= 5), (j == 5), 1'b0, (j >= 2 && j <= 4),
                    (j >= 5) ? 3'd1 : 3'd0};
            n_vec++;
            if (obs !== want || obs !== exp_vec()) begin
                n_err++;
                $display("FAIL release_high j=%0d: got %b want %b", j, obs, want);
            end
        end
    endtask

    task automatic test_random();
        logic prev_pulse = 1'b0;
        for (int r = 0; r < 80; r++) begin
            dip_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 7)) begin
                @(negedge clk);
                n_vec++;
                if (obs !== exp_vec()) begin
                    n_err++;
                    $display("FAIL random: got %b want %b", obs, exp_vec());
                end
                if ((rise_pulse && fall_pulse) || (prev_pulse && (rise_pulse || fall_pulse))) begin
                    n_err++;
                    $display("FAIL random_pulse_rule: got r%b f%b prev %b want isolated pulses",
                             rise_pulse, fall_pulse, prev_pulse);
                end
                prev_pulse = rise_pulse | fall_pulse;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce_reject();
        test_bounce_settle();
        test_square_wave();
        test_reset_mid_qual();
        test_reset_release_high();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
